// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and widths for the multiply/divide sequencer
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative HI/LO multiply/divide unit (optional MULDIV_EARLY_OUT_EN)
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  muldiv_op_t       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  muldiv_state_t      state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p;        // {acc, multiplier} or {remainder, quotient}
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_lo;   // negate product / quotient
  logic               neg_hi;   // negate remainder

  logic               accept, op_div, op_sgn, a_neg, b_neg, zero_div, early;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH+1:0]   sub_diff;
  logic [2*WIDTH-1:0] p_step, mag;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign req_ready = (state == IDLE) && !abort;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign accept    = req_valid && req_ready;

  assign op_div   = (req_op == MD_DIV) || (req_op == MD_DIVU);
  assign op_sgn   = (req_op == MD_MULT) || (req_op == MD_DIV);
  assign a_neg    = op_sgn && req_a[WIDTH-1];
  assign b_neg    = op_sgn && req_b[WIDTH-1];
  assign a_mag    = a_neg ? -req_a : req_a;
  assign b_mag    = b_neg ? -req_b : req_b;
  assign zero_div = op_div && (req_b == '0);

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] mrem;  // multiplier bits not yet consumed

  // Shadow copy of the multiplier so the exit test needs no masking of p
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              mrem <= '0;
    else if (accept)         mrem <= b_mag;
    else if (state == CALC)  mrem <= mrem >> 1;
  end

  assign early = !is_div && (mrem[WIDTH-1:1] == '0);
  // A short multiply leaves the product high by the skipped iterations
  assign mag   = p >> (CW'(WIDTH) - cnt);
`else
  assign early = 1'b0;
  assign mag   = p;
`endif

  // One shift-add or restoring-subtract step on the 2W working register
  always_comb begin
    add_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? opnd : {WIDTH{1'b0}})};
    shl      = p[2*WIDTH-1:WIDTH-1];
    sub_diff = {1'b0, shl} - {2'b00, opnd};
    if (is_div)
      p_step = {(sub_diff[WIDTH+1] ? shl[WIDTH-1:0] : sub_diff[WIDTH-1:0]),
                p[WIDTH-2:0], ~sub_diff[WIDTH+1]};
    else
      p_step = {add_sum, p[WIDTH-1:1]};
  end

  // Sign fixup of the magnitude result
  always_comb begin
    res_hi = mag[2*WIDTH-1:WIDTH];
    res_lo = mag[WIDTH-1:0];
    if (is_div) begin
      if (neg_lo) res_lo = -mag[WIDTH-1:0];
      if (neg_hi) res_hi = -mag[2*WIDTH-1:WIDTH];
    end else if (neg_lo) begin
      {res_hi, res_lo} = -mag;
    end
  end

  // Next-state logic; abort always returns to IDLE without a done pulse
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_div ? DONE : CALC;
      CALC:    if (abort) state_nxt = IDLE;
               else if (cnt == CW'(WIDTH - 1) || early) state_nxt = FIXUP;
      FIXUP:   state_nxt = abort ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand latch and per-cycle iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      p      <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      p      <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
      opnd   <= op_div ? b_mag : a_mag;
      is_div <= op_div;
      neg_lo <= a_neg ^ b_neg;
      neg_hi <= op_div ? a_neg : (a_neg ^ b_neg);
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      p   <= p_step;
    end
  end

  // HI/LO only change when entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (accept && zero_div) begin
      hi       <= req_a;
      lo       <= {WIDTH{1'b1}};
      div_zero <= 1'b1;
    end else if (state == FIXUP && !abort) begin
      hi       <= res_hi;
      lo       <= res_lo;
      div_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  muldiv_op_t   req_op = MD_MULT;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         abort = 1'b0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .abort(abort),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Architectural result computed with plain integer arithmetic
  task automatic model(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic ez);
    logic [63:0] prod;
    int sa, sb;
    ez = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      MD_MULT:  begin prod = longint'(sa) * longint'(sb); eh = prod[63:32]; el = prod[31:0]; end
      MD_MULTU: begin prod = {32'd0, a} * {32'd0, b};     eh = prod[63:32]; el = prod[31:0]; end
      MD_DIV: begin
        if (b == 0) begin eh = a; el = '1; ez = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin el = a; eh = '0; end
        else begin el = sa / sb; eh = sa % sb; end
      end
      default: begin
        if (b == 0) begin eh = a; el = '1; ez = 1'b1; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endtask

  // Cycles from accept edge to the cycle where done is high
  function automatic int exp_lat(input muldiv_op_t op, input logic [W-1:0] b);
    if ((op == MD_DIV || op == MD_DIVU) && b == 0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (op == MD_MULT || op == MD_MULTU) begin
      logic [W-1:0] m;
      int nbits;
      m = (op == MD_MULT && b[W-1]) ? -b : b;
      nbits = 1;
      for (int i = 0; i < W; i++) if (m[i]) nbits = i + 1;
      return nbits + 2;
    end
`endif
    return W + 2;
  endfunction

  // Called right after the accept edge; returns on a negedge
  task automatic wait_result(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    logic ez;
    int k;
    model(op, a, b, eh, el, ez);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
      end
      if (done) begin k = i; break; end
    end
    chk("latency", k, exp_lat(op, b));
    chk("hi", hi, eh);
    chk("lo", lo, el);
    chk("div_zero", div_zero, ez);
    @(negedge clk);
    chk("done_pulse", done, 0);
    last_hi = eh;
    last_lo = el;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    chk("ready", req_ready, 1);
  endtask

  task automatic do_op(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    wait_ready();
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    wait_result(op, a, b);
  endtask

  initial begin
    int k, ndone;
    logic [W-1:0] eh, el;
    logic ez;
    muldiv_op_t rop;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);

    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(MD_MULT,  -32'sd3, 32'd7);
    do_op(MD_DIV,   -32'sd7, 32'd2);
    do_op(MD_DIVU,  32'd100, 32'd0);
    do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    do_op(MD_MULTU, 32'd5, 32'd1);
    do_op(MD_MULT,  32'd9, 32'd0);
    do_op(MD_DIV,   32'd0, 32'd0);

    for (int n = 0; n < 30; n++) begin
      rop = muldiv_op_t'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = $urandom_range(0, 15);
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb);
    end

    // Abort mid-divide
    wait_ready();
    req_valid = 1'b1; req_op = MD_DIVU; req_a = $urandom; req_b = 32'd3;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = 1'b0;
      if (i == 10) abort = 1'b1;
    end
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    abort = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_hi", hi, last_hi);
    chk("abort_lo", lo, last_lo);

    // Abort in IDLE beats req_valid
    abort = 1'b1; req_valid = 1'b1; req_op = MD_DIVU; req_a = 32'd9; req_b = 32'd3;
    #1 chk("idle_abort_ready", req_ready, 0);
    @(negedge clk);
    chk("idle_abort_busy", busy, 0);
    abort = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("idle_abort_hi", hi, last_hi);
    chk("idle_abort_lo", lo, last_lo);

    // Back-to-back with req_valid held through the first op
    wait_ready();
    req_valid = 1'b1; req_op = MD_DIVU; req_a = 32'd1000; req_b = 32'd7;
    @(posedge clk);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) begin req_op = MD_MULT; req_a = 32'd12345; req_b = -32'sd678; end
      if (req_ready) begin k = i; break; end
    end
    chk("b2b_accept_cycle", k, W + 3);
    model(MD_DIVU, 32'd1000, 32'd7, eh, el, ez);
    chk("b2b_first_hi", hi, eh);
    chk("b2b_first_lo", lo, el);
    @(posedge clk);
    wait_result(MD_MULT, 32'd12345, -32'sd678);

    // Reset while in CALC
    wait_ready();
    req_valid = 1'b1; req_op = MD_MULTU; req_a = $urandom; req_b = 32'hFFFF_0000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_div_zero", div_zero, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(MD_MULTU, 32'd5, 32'd1);
    do_op(MD_MULT, 32'd3, -32'sd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
